// File: rtl/mult_pipe_nxn_if.sv
// Operand/result handshake bundle for the pipelined NxN multiplier.
interface mult_pipe_nxn_if #(
  parameter int WIDTH = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_1;
  logic [WIDTH-1:0]   in_2;
  logic               mode_signed;
  logic               mode_sat;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   prod;
  logic [2*WIDTH-1:0] prod_full;
  logic               ovf;

  modport slave (
    input  in_valid, in_1, in_2, mode_signed, mode_sat, out_ready,
    output in_ready, out_valid, prod, prod_full, ovf
  );

  modport master (
    output in_valid, in_1, in_2, mode_signed, mode_sat, out_ready,
    input  in_ready, out_valid, prod, prod_full, ovf
  );
endinterface

// File: rtl/mult_pipe_nxn.sv
// Pipelined NxN multiplier with valid/ready stall, per-beat signed/saturate modes
// and wrap/saturate narrowing with overflow flag.
module mult_pipe_nxn #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 3
) (
  input  logic             clk,
  input  logic             rst,
  mult_pipe_nxn_if.slave   bus
);
  localparam int W2 = 2 * WIDTH;

  logic              advance, accept;
  logic [STAGES:1]   vld_q;
  logic [STAGES:0]   vld_pipe;
  logic [W2-1:0]     a_ext, b_ext, mul_full;
  logic [1:0]        md_in;   // {signed, sat}
  logic [W2-1:0]     nf;
  logic [1:0]        nm;
  logic [WIDTH-1:0]  nprod;
  logic              novf;

  // Whole pipe moves together; bubbles are kept, not squeezed out.
  assign advance       = !vld_q[STAGES] || bus.out_ready;
  assign bus.in_ready  = advance;
  assign accept        = bus.in_valid && advance;
  assign vld_pipe      = {vld_q, accept};
  assign bus.out_valid = vld_q[STAGES];
  assign md_in         = {bus.mode_signed, bus.mode_sat};

  // Extending to 2W first makes one multiplier serve both signednesses.
  always_comb begin
    a_ext    = bus.mode_signed ? {{WIDTH{bus.in_1[WIDTH-1]}}, bus.in_1}
                               : {{WIDTH{1'b0}}, bus.in_1};
    b_ext    = bus.mode_signed ? {{WIDTH{bus.in_2[WIDTH-1]}}, bus.in_2}
                               : {{WIDTH{1'b0}}, bus.in_2};
    mul_full = a_ext * b_ext;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          vld_q <= '0;
    else if (advance) vld_q <= vld_pipe[STAGES-1:0];
  end

  generate
    if (STAGES == 1) begin : g_single
      assign nf = mul_full;
      assign nm = md_in;
    end else begin : g_multi
      for (genvar s = 1; s < STAGES; s++) begin : g_st
        logic [W2-1:0] pf;
        logic [1:0]    md;
        if (s == 1) begin : g_first
          always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
              pf <= '0;
              md <= '0;
            end else if (advance && vld_pipe[0]) begin
              pf <= mul_full;
              md <= md_in;
            end
          end
        end else begin : g_carry
          always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
              pf <= '0;
              md <= '0;
            end else if (advance && vld_pipe[s-1]) begin
              pf <= g_st[s-1].pf;
              md <= g_st[s-1].md;
            end
          end
        end
      end
      assign nf = g_st[STAGES-1].pf;
      assign nm = g_st[STAGES-1].md;
    end
  endgenerate

  // Signed fits iff the top W+1 bits are all equal (pure sign extension).
  always_comb begin
    novf  = nm[1] ? !((&nf[W2-1:WIDTH-1]) || !(|nf[W2-1:WIDTH-1]))
                  : |nf[W2-1:WIDTH];
    nprod = nf[WIDTH-1:0];
    if (nm[0] && novf) begin
      if (!nm[1])         nprod = '1;
      else if (nf[W2-1])  nprod = {1'b1, {(WIDTH-1){1'b0}}};
      else                nprod = {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.prod      <= '0;
      bus.prod_full <= '0;
      bus.ovf       <= 1'b0;
    end else if (advance && vld_pipe[STAGES-1]) begin
      bus.prod      <= nprod;
      bus.prod_full <= nf;
      bus.ovf       <= novf;
    end
  end
endmodule

// File: tb/tb_mult_pipe_nxn.sv
// Bench for mult_pipe_nxn: an 8-bit/3-stage and a 16-bit/1-stage instance,
// table vectors plus scoreboard-checked streams, stall and reset sequences.
module tb_mult_pipe_nxn;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mult_pipe_nxn_if #(.WIDTH(8))  a8 ();
  mult_pipe_nxn_if #(.WIDTH(16)) a16 ();

  mult_pipe_nxn #(.WIDTH(8),  .STAGES(3)) u8  (.clk(clk), .rst(rst), .bus(a8));
  mult_pipe_nxn #(.WIDTH(16), .STAGES(1)) u16 (.clk(clk), .rst(rst), .bus(a16));

  typedef struct packed {
    logic [31:0] full;
    logic [15:0] prod;
    logic        ovf;
  } exp_t;

  typedef struct {
    logic [15:0] a, b;
    bit          sgn, sat;
    logic [15:0] prod;
    logic [31:0] full;
    bit          ovf;
  } vec_t;

  int   checks = 0, failures = 0;
  exp_t q8[$], q16[$];
  bit   sb_off8 = 1'b0;
  vec_t t8[15], t16[8];

  function automatic void chk(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endfunction

  // Reference product built from true integer values.
  function automatic exp_t model(int w, logic [15:0] a, logic [15:0] b, bit sgn, bit sat);
    longint one = 1;
    longint m, av, bv, pv;
    exp_t   e;
    m  = (one << w) - 1;
    av = longint'(a) & m;
    bv = longint'(b) & m;
    if (sgn) begin
      if (av >= (one << (w-1))) av -= (one << w);
      if (bv >= (one << (w-1))) bv -= (one << w);
    end
    pv = av * bv;
    if (sgn) e.ovf = (pv > (one << (w-1)) - 1) || (pv < -(one << (w-1)));
    else     e.ovf = pv > m;
    e.full = 32'(pv & ((one << (2*w)) - 1));
    if (sat && e.ovf)
      e.prod = !sgn ? 16'(m) : (pv < 0 ? 16'(one << (w-1)) : 16'((one << (w-1)) - 1));
    else
      e.prod = 16'(pv & m);
    return e;
  endfunction

  // Output monitors: scoreboard pop, handshake rule and hold-stable rule.
  logic       held8 = 1'b0, held16 = 1'b0;
  exp_t       s8, s16;
  always @(negedge clk) begin
    exp_t e;
    if (rst) held8 = 1'b0;
    else begin
      chk("in_ready8", 32'(a8.in_ready), 32'(!a8.out_valid || a8.out_ready));
      if (held8 && a8.out_valid) begin
        chk("hold8_prod", 32'(a8.prod), 32'(s8.prod));
        chk("hold8_full", 32'(a8.prod_full), s8.full);
        chk("hold8_ovf", 32'(a8.ovf), 32'(s8.ovf));
      end
      if (a8.out_valid && a8.out_ready && !sb_off8) begin
        if (q8.size() == 0) begin
          checks++; failures++;
          $display("FAIL sb8_unexpected got=%0h exp=none", a8.prod_full);
        end else begin
          e = q8.pop_front();
          chk("sb8_prod", 32'(a8.prod), 32'(e.prod));
          chk("sb8_full", 32'(a8.prod_full), e.full);
          chk("sb8_ovf", 32'(a8.ovf), 32'(e.ovf));
        end
      end
      held8 = a8.out_valid && !a8.out_ready;
      s8 = '{full: 32'(a8.prod_full), prod: 16'(a8.prod), ovf: a8.ovf};
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst) held16 = 1'b0;
    else begin
      chk("in_ready16", 32'(a16.in_ready), 32'(!a16.out_valid || a16.out_ready));
      if (held16 && a16.out_valid) begin
        chk("hold16_prod", 32'(a16.prod), 32'(s16.prod));
        chk("hold16_full", a16.prod_full, s16.full);
        chk("hold16_ovf", 32'(a16.ovf), 32'(s16.ovf));
      end
      if (a16.out_valid && a16.out_ready) begin
        if (q16.size() == 0) begin
          checks++; failures++;
          $display("FAIL sb16_unexpected got=%0h exp=none", a16.prod_full);
        end else begin
          e = q16.pop_front();
          chk("sb16_prod", 32'(a16.prod), 32'(e.prod));
          chk("sb16_full", a16.prod_full, e.full);
          chk("sb16_ovf", 32'(a16.ovf), 32'(e.ovf));
        end
      end
      held16 = a16.out_valid && !a16.out_ready;
      s16 = '{full: a16.prod_full, prod: a16.prod, ovf: a16.ovf};
    end
  end

  // All stimulus tasks are entered and left at posedge+1.
  task automatic send8(input logic [7:0] a, input logic [7:0] b, input bit s, input bit t,
                       input exp_t e, input bit push);
    int n = 0;
    a8.in_1 = a; a8.in_2 = b; a8.mode_signed = s; a8.mode_sat = t; a8.in_valid = 1'b1;
    #1;
    while (!a8.in_ready && n < 50) begin @(posedge clk); #2; n++; end
    if (!a8.in_ready) begin
      checks++; failures++;
      $display("FAIL send8_timeout got=%0d exp=<50", n);
    end else if (push) q8.push_back(e);
    @(posedge clk); #1;
    a8.in_valid = 1'b0;
  endtask

  task automatic send16(input logic [15:0] a, input logic [15:0] b, input bit s, input bit t,
                        input exp_t e);
    int n = 0;
    a16.in_1 = a; a16.in_2 = b; a16.mode_signed = s; a16.mode_sat = t; a16.in_valid = 1'b1;
    #1;
    while (!a16.in_ready && n < 50) begin @(posedge clk); #2; n++; end
    if (!a16.in_ready) begin
      checks++; failures++;
      $display("FAIL send16_timeout got=%0d exp=<50", n);
    end else q16.push_back(e);
    @(posedge clk); #1;
    a16.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q8.size() != 0 || q16.size() != 0) && n < 100) begin @(posedge clk); #1; n++; end
    chk("drain_q8", 32'(q8.size()), 32'd0);
    chk("drain_q16", 32'(q16.size()), 32'd0);
  endtask

  // Edges after the accepting edge until out_valid rises.
  task automatic latency(input bit wide, input int exp_n, input string nm);
    int n = 0;
    while (!(wide ? a16.out_valid : a8.out_valid) && n < 20) begin @(posedge clk); #1; n++; end
    chk(nm, 32'(n), 32'(exp_n));
  endtask

  task automatic stream8();
    int sent = 0, cyc = 0;
    bit acc, need = 1'b1;
    logic [7:0] a, b;
    bit s, t;
    while (sent < 10 && cyc < 60) begin
      if (need) begin a = 8'($urandom); b = 8'($urandom); s = 1'($urandom); t = 1'($urandom); end
      a8.out_ready = !(cyc >= 4 && cyc < 8);
      a8.in_1 = a; a8.in_2 = b; a8.mode_signed = s; a8.mode_sat = t; a8.in_valid = 1'b1;
      #1;
      acc = a8.in_ready;
      if (acc) q8.push_back(model(8, {8'd0, a}, {8'd0, b}, s, t));
      @(posedge clk); #1;
      if (acc) sent++;
      need = acc;
      cyc++;
    end
    a8.in_valid = 1'b0; a8.out_ready = 1'b1;
    chk("stream8_sent", 32'(sent), 32'd10);
  endtask

  task automatic stream16();
    int sent = 0, cyc = 0;
    bit acc, need = 1'b1;
    logic [15:0] a, b;
    bit s, t;
    while (sent < 10 && cyc < 60) begin
      if (need) begin a = 16'($urandom); b = 16'($urandom); s = 1'($urandom); t = 1'($urandom); end
      a16.out_ready = !(cyc >= 4 && cyc < 8);
      a16.in_1 = a; a16.in_2 = b; a16.mode_signed = s; a16.mode_sat = t; a16.in_valid = 1'b1;
      #1;
      acc = a16.in_ready;
      if (acc) q16.push_back(model(16, a, b, s, t));
      @(posedge clk); #1;
      if (acc) sent++;
      need = acc;
      cyc++;
    end
    a16.in_valid = 1'b0; a16.out_ready = 1'b1;
    chk("stream16_sent", 32'(sent), 32'd10);
  endtask

  initial begin #200000; $display("FAIL watchdog got=timeout exp=finish"); $fatal(1); end

  initial begin
    bit stale;
    //            a        b        sgn sat prod     full          ovf
    t8[0]  = '{16'd5,   16'd4,   0, 0, 16'h14, 32'h0014, 1'b0};
    t8[1]  = '{16'd24,  16'd56,  0, 0, 16'h40, 32'h0540, 1'b1};
    t8[2]  = '{16'd24,  16'd56,  0, 1, 16'hFF, 32'h0540, 1'b1};
    t8[3]  = '{16'd100, 16'd200, 0, 0, 16'h20, 32'h4E20, 1'b1};
    t8[4]  = '{16'hFD,  16'd6,   1, 0, 16'hEE, 32'hFFEE, 1'b0};
    t8[5]  = '{16'd100, 16'd100, 1, 1, 16'h7F, 32'h2710, 1'b1};
    t8[6]  = '{16'h80,  16'hFF,  1, 0, 16'h80, 32'h0080, 1'b1};
    t8[7]  = '{16'h80,  16'hFF,  1, 1, 16'h7F, 32'h0080, 1'b1};
    t8[8]  = '{16'h80,  16'd2,   1, 1, 16'h80, 32'hFF00, 1'b1};
    t8[9]  = '{16'h80,  16'd2,   1, 0, 16'h00, 32'hFF00, 1'b1};
    t8[10] = '{16'hFF,  16'hFF,  0, 1, 16'hFF, 32'hFE01, 1'b1};
    t8[11] = '{16'hFF,  16'hFF,  1, 1, 16'h01, 32'h0001, 1'b0};
    t8[12] = '{16'h7F,  16'hFF,  1, 1, 16'h81, 32'hFF81, 1'b0};
    t8[13] = '{16'd16,  16'd16,  0, 0, 16'h00, 32'h0100, 1'b1};
    t8[14] = '{16'd15,  16'd17,  0, 1, 16'hFF, 32'h00FF, 1'b0};
    t16[0] = '{16'd5,    16'd4,    0, 0, 16'h0014, 32'h00000014, 1'b0};
    t16[1] = '{16'd300,  16'd300,  0, 0, 16'h5F90, 32'h00015F90, 1'b1};
    t16[2] = '{16'd300,  16'd300,  0, 1, 16'hFFFF, 32'h00015F90, 1'b1};
    t16[3] = '{16'd300,  16'd300,  1, 1, 16'h7FFF, 32'h00015F90, 1'b1};
    t16[4] = '{16'h8000, 16'hFFFF, 1, 1, 16'h7FFF, 32'h00008000, 1'b1};
    t16[5] = '{16'hFFFD, 16'd6,    1, 0, 16'hFFEE, 32'hFFFFFFEE, 1'b0};
    t16[6] = '{16'd255,  16'd256,  0, 1, 16'hFF00, 32'h0000FF00, 1'b0};
    t16[7] = '{16'h8000, 16'd2,    1, 1, 16'h8000, 32'hFFFF0000, 1'b1};

    rst = 1'b1;
    a8.in_valid = 0;  a8.in_1 = 0;  a8.in_2 = 0;  a8.mode_signed = 0;  a8.mode_sat = 0;  a8.out_ready = 1;
    a16.in_valid = 0; a16.in_1 = 0; a16.in_2 = 0; a16.mode_signed = 0; a16.mode_sat = 0; a16.out_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst8_out_valid", 32'(a8.out_valid), 0);
    chk("rst8_prod", 32'(a8.prod), 0);
    chk("rst8_full", 32'(a8.prod_full), 0);
    chk("rst8_ovf", 32'(a8.ovf), 0);
    chk("rst8_in_ready", 32'(a8.in_ready), 1);
    chk("rst16_out_valid", 32'(a16.out_valid), 0);
    chk("rst16_full", a16.prod_full, 0);
    chk("rst16_in_ready", 32'(a16.in_ready), 1);
    rst = 1'b0;
    @(posedge clk); #1;

    // 8-bit / 3-stage: latency, table, stalled stream, reset with beats in flight
    send8(8'(t8[0].a), 8'(t8[0].b), t8[0].sgn, t8[0].sat,
          '{full: t8[0].full, prod: t8[0].prod, ovf: t8[0].ovf}, 1'b1);
    latency(1'b0, 2, "lat8");
    drain();
    for (int i = 0; i < 15; i++)
      send8(8'(t8[i].a), 8'(t8[i].b), t8[i].sgn, t8[i].sat,
            '{full: t8[i].full, prod: t8[i].prod, ovf: t8[i].ovf}, 1'b1);
    drain();
    stream8();
    drain();

    sb_off8 = 1'b1;
    for (int i = 0; i < 3; i++) send8(8'(i + 1), 8'd3, 1'b0, 1'b0, '0, 1'b0);
    rst = 1'b1;
    #1;
    chk("arst8_out_valid", 32'(a8.out_valid), 0);
    chk("arst8_prod", 32'(a8.prod), 0);
    chk("arst8_full", 32'(a8.prod_full), 0);
    chk("arst8_ovf", 32'(a8.ovf), 0);
    chk("arst8_in_ready", 32'(a8.in_ready), 1);
    @(posedge clk); #1;
    rst = 1'b0;
    sb_off8 = 1'b0;
    stale = 1'b0;
    repeat (6) begin @(posedge clk); #1; if (a8.out_valid) stale = 1'b1; end
    chk("stale8", 32'(stale), 0);
    send8(8'd7, 8'd9, 1'b0, 1'b0, model(8, 16'd7, 16'd9, 1'b0, 1'b0), 1'b1);
    latency(1'b0, 2, "lat8_post_rst");
    drain();

    // 16-bit / 1-stage
    send16(t16[1].a, t16[1].b, t16[1].sgn, t16[1].sat,
           '{full: t16[1].full, prod: t16[1].prod, ovf: t16[1].ovf});
    latency(1'b1, 0, "lat16");
    drain();
    for (int i = 0; i < 8; i++)
      send16(t16[i].a, t16[i].b, t16[i].sgn, t16[i].sat,
             '{full: t16[i].full, prod: t16[i].prod, ovf: t16[i].ovf});
    drain();
    stream16();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
